mem_stage: RTL and testbench

- MEM pipeline stage of the five-stage RV32I core.
- Sits between the EX/MEM register and the data memory, and produces the MEM/WB register.
- Drives the combinational data-memory port (address, read_write, data_in, access_size) from the instruction currently in MEM.
- Sign- or zero-extends load data, checks alignment and address range, and registers results for writeback. Also keeps load/store event counters.

---
 rtl/mem_stage_pkg.sv | 38 +++
 rtl/mem_stage_if.sv | 18 +
 rtl/mem_stage_load_extend.sv | 25 ++
 rtl/mem_stage.sv | 148 ++++++++++++++
 tb/tb_mem_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the RV32I MEM stage: funct3 encodings, access sizes,
// fault FSM states and the default data-memory window.
package mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } access_size_e;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_FAULTED = 1'b1
  } fault_state_e;

  // Data memory decodes from this base; keep in step with the memory's address shift.
  localparam logic [31:0] DMEM_BASE_DEFAULT  = 32'h0100_0000;
  localparam int unsigned DMEM_BYTES_DEFAULT = 1048576;

  function automatic logic [2:0] access_bytes(input access_size_e size);
    case (size)
      SIZE_BYTE: access_bytes = 3'd1;
      SIZE_HALF: access_bytes = 3'd2;
      default:   access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Combinational data-memory port driven by the MEM stage.
interface mem_stage_if;
  logic [31:0] dmem_address;
  logic        dmem_read_write;
  logic [31:0] dmem_data_in;
  logic [1:0]  dmem_access_size;
  logic [31:0] dmem_data_out;

  modport master (
    output dmem_address, dmem_read_write, dmem_data_in, dmem_access_size,
    input  dmem_data_out
  );

  modport slave (
    input  dmem_address, dmem_read_write, dmem_data_in, dmem_access_size,
    output dmem_data_out
  );
endinterface

// File: rtl/mem_stage_load_extend.sv
// Load data extension from raw little-endian memory data; flags funct3
// values that are not legal RV32I loads.
module mem_stage_load_extend
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] raw_i,
  output logic [31:0] data_o,
  output logic        illegal_o
);

  always_comb begin
    data_o    = '0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_LB:   data_o = {{24{raw_i[7]}}, raw_i[7:0]};
      F3_LH:   data_o = {{16{raw_i[15]}}, raw_i[15:0]};
      F3_LW:   data_o = raw_i;
      F3_LBU:  data_o = {24'd0, raw_i[7:0]};
      F3_LHU:  data_o = {16'd0, raw_i[15:0]};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: drives the data-memory port, checks range/alignment,
// extends load data and produces the MEM/WB register plus event counters.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE   = DMEM_BASE_DEFAULT,
  parameter int unsigned DMEM_BYTES  = DMEM_BYTES_DEFAULT,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_rs2_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_wen,
  input  logic        stall,
  input  logic        flush,
  mem_stage_if.master dmem,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_wen,
  output logic [31:0] wb_data,
  output logic        wb_fault,
  output logic [31:0] wb_fault_addr,
  output logic [31:0] fwd_data,
  output logic [31:0] load_count,
  output logic [31:0] store_count
);

  localparam logic [32:0] DMEM_LIMIT = {1'b0, DMEM_BASE} + 33'(DMEM_BYTES);

  fault_state_e state_q, state_d;
  logic         wb_valid_q, wb_valid_d;
  logic [4:0]   wb_rd_q, wb_rd_d;
  logic         wb_reg_wen_q, wb_reg_wen_d;
  logic [31:0]  wb_data_q, wb_data_d;
  logic [31:0]  fault_addr_q, fault_addr_d;
  logic [31:0]  load_count_q, load_count_d;
  logic [31:0]  store_count_q, store_count_d;

  logic        mem_op, out_of_range, misaligned, fault_now;
  logic        faulted, go, capture_fault, ext_illegal;
  logic [32:0] access_end;
  logic [31:0] ext_data;

  mem_stage_load_extend u_load_extend (
    .funct3_i  (ex_funct3),
    .raw_i     (dmem.dmem_data_out),
    .data_o    (ext_data),
    .illegal_o (ext_illegal)
  );

  always_comb begin
    mem_op       = ex_valid & (ex_is_load | ex_is_store);
    // 33-bit end address so accesses touching the top of the 4 GiB space cannot wrap.
    access_end   = {1'b0, ex_alu_result} + {30'd0, access_bytes(access_size_e'(ex_funct3[1:0]))};
    out_of_range = (ex_alu_result < DMEM_BASE) | (access_end > DMEM_LIMIT);
    misaligned   = 1'b0;
    if (ALIGN_CHECK) begin
      case (access_size_e'(ex_funct3[1:0]))
        SIZE_HALF: misaligned = ex_alu_result[0];
        SIZE_WORD: misaligned = |ex_alu_result[1:0];
        default:   misaligned = 1'b0;
      endcase
    end
    fault_now     = mem_op & (out_of_range | misaligned | (ex_is_load & ext_illegal));
    faulted       = (state_q == ST_FAULTED);
    go            = ex_valid & ~stall & ~flush & ~fault_now & ~faulted;
    capture_fault = fault_now & ~stall & ~flush & ~faulted;
  end

  // The memory writes combinationally, so the write strobe is gated here, including by reset.
  assign dmem.dmem_address     = ex_alu_result;
  assign dmem.dmem_data_in     = ex_rs2_data;
  assign dmem.dmem_access_size = mem_op ? ex_funct3[1:0] : '0;
  assign dmem.dmem_read_write  = go & ex_is_store & ~reset;

  assign fwd_data = ex_is_load ? ext_data : ex_alu_result;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (capture_fault) state_d = ST_FAULTED;
      ST_FAULTED: state_d = ST_FAULTED;
      default:    state_d = ST_RUN;
    endcase
  end

  always_comb begin
    wb_valid_d    = wb_valid_q;
    wb_rd_d       = wb_rd_q;
    wb_reg_wen_d  = wb_reg_wen_q;
    wb_data_d     = wb_data_q;
    fault_addr_d  = fault_addr_q;
    load_count_d  = load_count_q;
    store_count_d = store_count_q;
    if (!stall) begin
      wb_valid_d   = 1'b0;
      wb_reg_wen_d = 1'b0;
      if (capture_fault) begin
        fault_addr_d = ex_alu_result;
      end else if (go) begin
        wb_valid_d   = 1'b1;
        wb_rd_d      = ex_rd;
        wb_reg_wen_d = ex_reg_wen & (ex_rd != '0);
        wb_data_d    = fwd_data;
      end
    end
    if (go & ex_is_load)  load_count_d  = load_count_q + 32'd1;
    if (go & ex_is_store) store_count_d = store_count_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_RUN;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_reg_wen_q  <= 1'b0;
      wb_data_q     <= '0;
      fault_addr_q  <= '0;
      load_count_q  <= '0;
      store_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_reg_wen_q  <= wb_reg_wen_d;
      wb_data_q     <= wb_data_d;
      fault_addr_q  <= fault_addr_d;
      load_count_q  <= load_count_d;
      store_count_q <= store_count_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_reg_wen    = wb_reg_wen_q;
  assign wb_data       = wb_data_q;
  assign wb_fault      = (state_q == ST_FAULTED);
  assign wb_fault_addr = fault_addr_q;
  assign load_count    = load_count_q;
  assign store_count   = store_count_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: two instances (alignment checking on/off)
// share stimulus; a byte-level memory model supplies load data.
module tb_mem_stage;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int unsigned BYTES = 1048576;
  localparam logic [31:0] TOP   = BASE + 32'(BYTES);

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_alu_result = '0, ex_rs2_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_wen = 1'b0, stall = 1'b0, flush = 1'b0;

  logic [1:0]  wb_valid, wb_reg_wen, wb_fault;
  logic [4:0]  wb_rd [2];
  logic [31:0] wb_data [2], wb_fault_addr [2], fwd_data [2], load_count [2], store_count [2];

  mem_stage_if dif0 ();
  mem_stage_if dif1 ();

  mem_stage #(.ALIGN_CHECK(1'b1)) dut0 (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result),
    .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen), .stall(stall),
    .flush(flush), .dmem(dif0), .wb_valid(wb_valid[0]), .wb_rd(wb_rd[0]),
    .wb_reg_wen(wb_reg_wen[0]), .wb_data(wb_data[0]), .wb_fault(wb_fault[0]),
    .wb_fault_addr(wb_fault_addr[0]), .fwd_data(fwd_data[0]),
    .load_count(load_count[0]), .store_count(store_count[0])
  );

  mem_stage #(.ALIGN_CHECK(1'b0)) dut1 (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result),
    .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen), .stall(stall),
    .flush(flush), .dmem(dif1), .wb_valid(wb_valid[1]), .wb_rd(wb_rd[1]),
    .wb_reg_wen(wb_reg_wen[1]), .wb_data(wb_data[1]), .wb_fault(wb_fault[1]),
    .wb_fault_addr(wb_fault_addr[1]), .fwd_data(fwd_data[1]),
    .load_count(load_count[1]), .store_count(store_count[1])
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t sbq0 [$];
  wb_exp_t sbq1 [$];

  // env*: what the DUT actually wrote; mdl*: what it should have written.
  logic [7:0] env0 [logic [31:0]];
  logic [7:0] env1 [logic [31:0]];
  logic [7:0] mdl0 [logic [31:0]];
  logic [7:0] mdl1 [logic [31:0]];

  bit          m_valid [2], m_wen [2], m_fault [2];
  bit [4:0]    m_rd [2];
  bit [31:0]   m_data [2], m_faddr [2], m_lc [2], m_sc [2];
  int unsigned m_writes [2], wcnt [2];

  int errors = 0;
  int checks = 0;
  logic upd = 1'b0;

  logic [31:0] plan_exp [5] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_F0FF, 32'h0000_F0FF, 32'h8000_F0FF};
  logic [2:0]  plan_f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [2:0]  load_f3  [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  // sel: 0/1 = environment memory of dut0/dut1, 2/3 = reference memory.
  function automatic logic [31:0] mem_rd(input int sel, input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] ai;
    logic [7:0]  b;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      ai = a + 32'(i);
      b  = '0;
      case (sel)
        0:       if (env0.exists(ai)) b = env0[ai];
        1:       if (env1.exists(ai)) b = env1[ai];
        2:       if (mdl0.exists(ai)) b = mdl0[ai];
        default: if (mdl1.exists(ai)) b = mdl1[ai];
      endcase
      w[8*i +: 8] = b;
    end
    return w;
  endfunction

  task automatic mem_wr(input int sel, input logic [31:0] a, input logic [31:0] wd, input int nb);
    logic [31:0] ai;
    for (int i = 0; i < nb; i++) begin
      ai = a + 32'(i);
      case (sel)
        0:       env0[ai] = wd[8*i +: 8];
        1:       env1[ai] = wd[8*i +: 8];
        2:       mdl0[ai] = wd[8*i +: 8];
        default: mdl1[ai] = wd[8*i +: 8];
      endcase
    end
  endtask

  task automatic check_state(input int d);
    string p;
    p = $sformatf("d%0d", d);
    chk({p, " wb_valid"},   32'(wb_valid[d]),   32'(m_valid[d]));
    chk({p, " wb_reg_wen"}, 32'(wb_reg_wen[d]), 32'(m_wen[d]));
    chk({p, " wb_rd"},      32'(wb_rd[d]),      32'(m_rd[d]));
    chk({p, " wb_data"},    wb_data[d],         m_data[d]);
    chk({p, " wb_fault"},   32'(wb_fault[d]),   32'(m_fault[d]));
    chk({p, " fault_addr"}, wb_fault_addr[d],   m_faddr[d]);
    chk({p, " load_count"}, load_count[d],      m_lc[d]);
    chk({p, " store_count"}, store_count[d],    m_sc[d]);
    chk({p, " mem_writes"}, wcnt[d],            m_writes[d]);
  endtask

  // One clock of stimulus: check registered state, drive, check combinational
  // outputs, record actual writes, then advance the reference model.
  task automatic cyc(input bit rst, input bit v, input bit ld, input bit st,
                     input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [4:0] rd, input bit wen, input bit stl, input bit fl);
    int nb;
    bit illegal, oor, mis, fnow, go, rw_act;
    logic [31:0] w, exp_fwd;
    wb_exp_t e;
    @(negedge clock);
    check_state(0);
    check_state(1);
    reset = rst; ex_valid = v; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_alu_result = addr; ex_rs2_data = wd; ex_rd = rd; ex_reg_wen = wen;
    stall = stl; flush = fl;
    dif0.dmem_data_out = mem_rd(0, addr);
    dif1.dmem_data_out = mem_rd(1, addr);
    #2;
    for (int d = 0; d < 2; d++) begin
      nb      = nbytes(f3[1:0]);
      illegal = ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      oor     = (addr < BASE) || (longint'(addr) + longint'(nb) > longint'(TOP));
      mis     = (d == 0) && ((addr % 32'(nb)) != 0);
      fnow    = v && (ld || st) && (oor || mis || illegal);
      go      = v && !stl && !fl && !fnow && !m_fault[d];
      w       = mem_rd(2 + d, addr);
      exp_fwd = addr;
      if (ld) begin
        case (f3)
          3'd0:    exp_fwd = int'($signed(w[7:0]));
          3'd1:    exp_fwd = int'($signed(w[15:0]));
          3'd4:    exp_fwd = w & 32'h0000_00FF;
          3'd5:    exp_fwd = w & 32'h0000_FFFF;
          default: exp_fwd = w;
        endcase
      end
      rw_act = (d == 0) ? dif0.dmem_read_write : dif1.dmem_read_write;
      chk($sformatf("d%0d read_write", d), 32'(rw_act), 32'(go && st && !rst));
      chk($sformatf("d%0d access_size", d),
          32'((d == 0) ? dif0.dmem_access_size : dif1.dmem_access_size),
          (v && (ld || st)) ? 32'(f3[1:0]) : 32'd0);
      if (v && !fnow) chk($sformatf("d%0d fwd_data", d), fwd_data[d], exp_fwd);
      if (rw_act) begin
        if (d == 0) mem_wr(0, dif0.dmem_address, dif0.dmem_data_in, nbytes(dif0.dmem_access_size));
        else        mem_wr(1, dif1.dmem_address, dif1.dmem_data_in, nbytes(dif1.dmem_access_size));
        wcnt[d]++;
      end
      if (rst) begin
        m_valid[d] = 0; m_wen[d] = 0; m_fault[d] = 0; m_rd[d] = '0;
        m_data[d] = '0; m_faddr[d] = '0; m_lc[d] = '0; m_sc[d] = '0;
      end else if (!stl) begin
        m_valid[d] = 0;
        m_wen[d]   = 0;
        if (fnow && !fl && !m_fault[d]) begin
          m_fault[d] = 1;
          m_faddr[d] = addr;
        end else if (go) begin
          m_valid[d] = 1;
          m_rd[d]    = rd;
          m_wen[d]   = wen && (rd != 0);
          m_data[d]  = exp_fwd;
          e = '{rd, wen && (rd != 0), exp_fwd};
          if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
          if (ld) m_lc[d]++;
          if (st) begin
            m_sc[d]++;
            m_writes[d]++;
            mem_wr(2 + d, addr, wd, nb);
          end
        end
      end
    end
  endtask

  task automatic op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [4:0] rd, input bit stl, input bit fl);
    cyc(1'b0, 1'b1, ld, st, f3, addr, wd, rd, ld, stl, fl);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mon(input int d);
    wb_exp_t e;
    int sz;
    sz = (d == 0) ? sbq0.size() : sbq1.size();
    if (wb_valid[d]) begin
      chk($sformatf("d%0d sb expected pending", d), 32'(sz != 0), 32'd1);
      if (sz != 0) begin
        if (d == 0) e = sbq0.pop_front(); else e = sbq1.pop_front();
        chk($sformatf("d%0d sb rd", d),   32'(wb_rd[d]),      32'(e.rd));
        chk($sformatf("d%0d sb wen", d),  32'(wb_reg_wen[d]), 32'(e.wen));
        chk($sformatf("d%0d sb data", d), wb_data[d],         e.data);
      end
    end
  endtask

  always @(posedge clock) upd <= !stall || reset;

  initial begin
    forever begin
      @(negedge clock);
      if (upd) begin
        mon(0);
        mon(1);
      end
    end
  end

  int unsigned k, off, nbr;
  logic [2:0]  rf3;
  logic [31:0] raddr;
  bit          rld, rst_, rwen;

  initial begin
    do_reset();
    do_reset();
    idle();

    // store then the five load flavours from the same word
    op(0, 1, 3'd2, BASE + 32'h10, 32'h8000_F0FF, 5'd0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      op(1, 0, plan_f3[i], BASE + 32'h10, '0, 5'(i + 1), 0, 0);
      chk($sformatf("plan load f3=%0d", plan_f3[i]), fwd_data[0], plan_exp[i]);
    end
    idle();

    // stalled store: no write until released, then exactly one
    for (int i = 0; i < 3; i++) begin
      op(0, 1, 3'd2, BASE + 32'h20, 32'h1122_3344, 5'd0, 1, 0);
      chk("stall mem untouched", mem_rd(0, BASE + 32'h20), 32'd0);
    end
    op(0, 1, 3'd2, BASE + 32'h20, 32'h1122_3344, 5'd0, 0, 0);
    chk("stall release write", mem_rd(0, BASE + 32'h20), 32'h1122_3344);
    idle();
    chk("stall store_count", store_count[0], 32'd2);

    // flushed byte store
    op(0, 1, 3'd0, BASE + 32'h28, 32'h0000_00AA, 5'd0, 0, 1);
    idle();
    chk("flush store_count", store_count[0], 32'd2);
    chk("flush mem untouched", mem_rd(0, BASE + 32'h28), 32'd0);

    // randomized aligned traffic with stalls and flushes
    repeat (300) begin
      k     = $urandom_range(0, 3);
      off   = $urandom_range(0, 255);
      rld   = (k == 1 || k == 3);
      rst_  = (k == 2);
      rwen  = ($urandom_range(0, 1) == 1);
      if (rld)       rf3 = load_f3[$urandom_range(0, 4)];
      else if (rst_) rf3 = 3'($urandom_range(0, 2));
      else           rf3 = 3'($urandom);
      nbr   = 32'(nbytes(rf3[1:0]));
      raddr = (k == 0) ? 32'($urandom) : BASE + (off & ~(nbr - 1));
      cyc(1'b0, $urandom_range(0, 7) != 0, rld, rst_, rf3, raddr, 32'($urandom),
          5'($urandom), (k == 0) ? rwen : rld,
          $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end
    idle();

    // address range
    do_reset();
    op(0, 1, 3'd2, 32'h00FF_FFFC, 32'hDEAD_BEEF, 5'd0, 0, 0);
    idle();
    chk("range low fault d0", 32'(wb_fault[0]), 32'd1);
    chk("range low fault d1", 32'(wb_fault[1]), 32'd1);
    chk("range low addr", wb_fault_addr[0], 32'h00FF_FFFC);
    do_reset();
    op(0, 1, 3'd2, TOP - 32'd2, 32'hDEAD_BEEF, 5'd0, 0, 0);
    idle();
    chk("range high fault d1", 32'(wb_fault[1]), 32'd1);
    chk("range high addr", wb_fault_addr[1], TOP - 32'd2);
    do_reset();
    op(0, 1, 3'd2, TOP - 32'd4, 32'hCAFE_F00D, 5'd0, 0, 0);
    idle();
    chk("range last word no fault", 32'(wb_fault[0]), 32'd0);
    chk("range last word data", mem_rd(0, TOP - 32'd4), 32'hCAFE_F00D);

    // misalignment: dut0 faults, dut1 proceeds
    do_reset();
    op(1, 0, 3'd2, BASE + 32'h2, '0, 5'd7, 0, 0);
    idle();
    chk("misalign fault d0", 32'(wb_fault[0]), 32'd1);
    chk("misalign addr d0", wb_fault_addr[0], BASE + 32'h2);
    chk("misalign no fault d1", 32'(wb_fault[1]), 32'd0);
    chk("misalign load_count d1", load_count[1], 32'd1);
    op(0, 1, 3'd2, BASE + 32'h10, 32'h55AA_55AA, 5'd0, 0, 0);
    chk("faulted store suppressed", 32'(dif0.dmem_read_write), 32'd0);
    op(1, 0, 3'd1, BASE + 32'h11, '0, 5'd3, 0, 0);
    idle();
    chk("fault addr frozen", wb_fault_addr[0], BASE + 32'h2);

    // reset in the middle of a store, then a load to x0
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, BASE + 32'h30, 32'h0BAD_0BAD, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("reset store suppressed", 32'(dif0.dmem_read_write), 32'd0);
    idle();
    chk("post-reset fault", 32'(wb_fault[0]), 32'd0);
    chk("post-reset load_count", load_count[0], 32'd0);
    op(1, 0, 3'd2, TOP - 32'd4, '0, 5'd0, 0, 0);
    idle();
    chk("x0 load valid", 32'(wb_valid[0]), 32'd1);
    chk("x0 load wen", 32'(wb_reg_wen[0]), 32'd0);
    chk("x0 load_count", load_count[0], 32'd1);

    idle();
    idle();
    chk("d0 scoreboard drained", 32'(sbq0.size()), 32'd0);
    chk("d1 scoreboard drained", 32'(sbq1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
